// File: rtl/spi_ram_master.sv
// SPI master for a serial RAM: each host request becomes two 10-bit frames
// (command + address, then command + data), with an optional read-back phase.
module spi_ram_master #(
  parameter int unsigned ADDR_SIZE   = 8,
  parameter int unsigned TURN_CYCLES = 2
) (
  input  logic                 CLK,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [7:0]           req_wdata,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);

  typedef enum logic [2:0] {IDLE, CMD, SHIFT, TURN, RECV, GAP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        second;
  logic        is_wr;
  logic [7:0]  wdata_q;
  logic [9:0]  frame;
  logic [7:0]  rx;
  logic [7:0]  addr_ext;

  assign addr_ext  = 8'(req_addr);
  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      second    <= 1'b0;
      is_wr     <= 1'b0;
      wdata_q   <= '0;
      frame     <= '0;
      rx        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            is_wr   <= req_wr;
            wdata_q <= req_wdata;
            frame   <= {req_wr ? 2'b00 : 2'b10, addr_ext};
            MOSI    <= ~req_wr;
            SS_n    <= 1'b0;
            second  <= 1'b0;
            state   <= CMD;
          end
        end
        CMD: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          // MOSI already shows the current bit; preload the next one so the
          // output stays a plain register.
          if (cnt == 4'd9) begin
            cnt  <= '0;
            MOSI <= 1'b0;
            if (!second || is_wr) begin
              SS_n  <= 1'b1;
              state <= GAP;
            end else if (TURN_CYCLES == 0) begin
              state <= RECV;
            end else begin
              state <= TURN;
            end
          end else begin
            MOSI  <= frame[8];
            frame <= {frame[8:0], 1'b0};
            cnt   <= cnt + 4'd1;
          end
        end
        TURN: begin
          if (cnt == 4'(TURN_CYCLES - 1)) begin
            cnt   <= '0;
            state <= RECV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RECV: begin
          rx <= {rx[6:0], MISO};
          if (cnt == 4'd7) begin
            rsp_data  <= {rx[6:0], MISO};
            rsp_valid <= 1'b1;
            SS_n      <= 1'b1;
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        GAP: begin
          if (!second) begin
            second <= 1'b1;
            frame  <= is_wr ? {2'b01, wdata_q} : {2'b11, 8'h00};
            MOSI   <= ~is_wr;
            SS_n   <= 1'b0;
            state  <= CMD;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_master.sv
// Randomized bench for spi_ram_master: per-cycle expectations derived from the
// frame layout and cycle timeline, with three TURN_CYCLES variants (2, 0, 15).
module tb_spi_ram_master;

  logic       CLK;
  logic       rst_n;
  logic       req_valid;
  logic       req_wr;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       MISO;
  logic [1:0] sel;

  logic [2:0] rv_in;
  logic [2:0] ready_v, rsp_valid_v, busy_v, ss_n_v, mosi_v;
  logic [7:0] rsp_data_v [3];

  logic       req_ready, rsp_valid, busy, ss_n, mosi;
  logic [7:0] rsp_data;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_rsp = 8'h00;

  assign rv_in[0] = req_valid && (sel == 2'd0);
  assign rv_in[1] = req_valid && (sel == 2'd1);
  assign rv_in[2] = req_valid && (sel == 2'd2);

  assign req_ready = ready_v[sel];
  assign rsp_valid = rsp_valid_v[sel];
  assign busy      = busy_v[sel];
  assign ss_n      = ss_n_v[sel];
  assign mosi      = mosi_v[sel];
  assign rsp_data  = rsp_data_v[sel];

  spi_ram_master #(.ADDR_SIZE(8), .TURN_CYCLES(2)) u_t2 (
    .CLK(CLK), .rst_n(rst_n), .req_valid(rv_in[0]), .req_ready(ready_v[0]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[0]), .rsp_data(rsp_data_v[0]), .busy(busy_v[0]),
    .SS_n(ss_n_v[0]), .MOSI(mosi_v[0]), .MISO(MISO));

  spi_ram_master #(.ADDR_SIZE(8), .TURN_CYCLES(0)) u_t0 (
    .CLK(CLK), .rst_n(rst_n), .req_valid(rv_in[1]), .req_ready(ready_v[1]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[1]), .rsp_data(rsp_data_v[1]), .busy(busy_v[1]),
    .SS_n(ss_n_v[1]), .MOSI(mosi_v[1]), .MISO(MISO));

  spi_ram_master #(.ADDR_SIZE(8), .TURN_CYCLES(15)) u_t15 (
    .CLK(CLK), .rst_n(rst_n), .req_valid(rv_in[2]), .req_ready(ready_v[2]),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid_v[2]), .rsp_data(rsp_data_v[2]), .busy(busy_v[2]),
    .SS_n(ss_n_v[2]), .MOSI(mosi_v[2]), .MISO(MISO));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Vector layout {SS_n, MOSI, rsp_valid, busy, req_ready}
  function automatic logic [4:0] sig_vec();
    return {ss_n, mosi, rsp_valid, busy, req_ready};
  endfunction

  // Called at a negedge while the selected instance is idle. Runs one
  // operation until its first IDLE cycle, or until abort_at (reset pulse).
  task automatic run_op(input bit wr, input logic [7:0] addr, input logic [7:0] wd,
                        input logic [7:0] rd, input int turn,
                        input bit hold, input bit nwr, input logic [7:0] naddr,
                        input logic [7:0] nwd, input int abort_at);
    logic [9:0] f1, f2;
    logic [4:0] exp;
    int recv0, gapc, last;
    f1 = {wr ? 2'b00 : 2'b10, addr};
    f2 = wr ? {2'b01, wd} : {2'b11, 8'h00};
    recv0 = 24 + turn;
    gapc  = wr ? 24 : recv0 + 8;
    last  = gapc + 1;

    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wd;
    chk("ready_before_accept", {7'd0, req_ready}, 8'd1);
    @(posedge CLK);
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        if (hold) begin
          req_valid = 1'b1; req_wr = nwr; req_addr = naddr; req_wdata = nwd;
        end else begin
          req_valid = 1'b0; req_wr = 1'($urandom);
          req_addr = 8'($urandom); req_wdata = 8'($urandom);
        end
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_async_vec", {3'd0, sig_vec()}, {3'd0, 5'b10001});
        chk("reset_rsp_data", rsp_data, 8'h00);
        model_rsp = 8'h00;
        @(negedge CLK);
        chk("reset_held_vec", {3'd0, sig_vec()}, {3'd0, 5'b10001});
        rst_n = 1'b1;
        return;
      end
      if (c <= 11)      exp = {1'b0, (c == 1) ? f1[9] : f1[11-c], 3'b010};
      else if (c == 12) exp = 5'b10010;
      else if (c <= 23) exp = {1'b0, (c == 13) ? f2[9] : f2[23-c], 3'b010};
      else if (c < gapc) exp = 5'b00010;
      else if (c == gapc) exp = wr ? 5'b10010 : 5'b10110;
      else               exp = 5'b10001;
      chk($sformatf("vec_c%0d", c), {3'd0, sig_vec()}, {3'd0, exp});
      if (!wr && c == gapc) model_rsp = rd;
      if (c >= gapc) chk("rsp_data", rsp_data, model_rsp);
      if (!wr && c >= recv0 && c < recv0 + 8) MISO = rd[7 - (c - recv0)];
      else MISO = 1'($urandom);
    end
  endtask

  initial begin
    logic [7:0] a, w, r;
    bit wr;
    sel = 2'd0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    MISO = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_vec", {3'd0, sig_vec()}, {3'd0, 5'b10001});
    chk("reset_data", rsp_data, 8'h00);
    rst_n = 1'b1;
    @(negedge CLK);

    run_op(1'b1, 8'h3C, 8'hA5, 8'h00, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_op(1'b0, 8'h3C, 8'h00, 8'hA5, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    repeat (3) @(negedge CLK);
    chk("rsp_data_hold", rsp_data, 8'hA5);
    chk("idle_vec", {3'd0, sig_vec()}, {3'd0, 5'b10001});

    // Back-to-back: next request held valid during the whole read.
    a = 8'($urandom); w = 8'($urandom); r = 8'($urandom);
    run_op(1'b0, 8'h51, 8'h00, r, 2, 1'b1, 1'b1, a, w, -1);
    run_op(1'b1, a, w, 8'h00, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);

    for (int i = 0; i < 6; i++) begin
      wr = 1'($urandom); a = 8'($urandom); w = 8'($urandom); r = 8'($urandom);
      run_op(wr, a, w, r, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    end

    // Reset during read-frame-2 RECV, after a read left rsp_data nonzero.
    run_op(1'b0, 8'h22, 8'h00, 8'h5A, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_op(1'b0, 8'h77, 8'h00, 8'hC3, 2, 1'b0, 1'b0, 8'h00, 8'h00, 29);
    run_op(1'b1, 8'h9E, 8'h3B, 8'h00, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_op(1'b0, 8'h9E, 8'h00, 8'h81, 2, 1'b0, 1'b0, 8'h00, 8'h00, -1);

    sel = 2'd1;
    model_rsp = 8'h00;
    run_op(1'b0, 8'h10, 8'h00, 8'hFF, 0, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_op(1'b0, 8'hEF, 8'h00, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_op(1'b1, 8'h01, 8'h7E, 8'h00, 0, 1'b0, 1'b0, 8'h00, 8'h00, -1);

    sel = 2'd2;
    model_rsp = 8'h00;
    run_op(1'b0, 8'h80, 8'h00, 8'hFF, 15, 1'b0, 1'b0, 8'h00, 8'h00, -1);
    run_op(1'b0, 8'h7F, 8'h00, 8'h00, 15, 1'b0, 1'b0, 8'h00, 8'h00, -1);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
